// File: rtl/cia_tod_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cia_tod_ctrl_pkg
//  Purpose  : Shared types and constants for the CIA time-of-day sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package cia_tod_ctrl_pkg;

  // CIA register address
  typedef logic [3:0] reg4_t;

  // Run state of the TOD clock
  typedef enum logic {TOD_STOPPED, TOD_RUNNING} tod_run_t;

  // Read-latch state: LIVE follows the clock, HELD freezes the read copy
  typedef enum logic {TOD_LIVE, TOD_HELD} tod_rd_t;

  // Pad-to-10Hz divide ratios
  localparam logic [2:0] TOD_DIV50 = 3'd5;
  localparam logic [2:0] TOD_DIV60 = 3'd6;

  // TOD register addresses that drive the state machines
  localparam reg4_t REG_TOD_10THS = 4'h8;
  localparam reg4_t REG_TOD_HR    = 4'hB;

endpackage
`default_nettype wire

// File: rtl/cia_tod_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cia_tod_ctrl_if
//  Purpose  : Bus, pad and enable signals between the CIA bus interface and
//             the TOD sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface cia_tod_ctrl_if;
  import cia_tod_ctrl_pkg::*;

  logic  phi2_up;
  logic  phi2_dn;
  logic  rd;
  logic  we;
  reg4_t addr;
  logic  w_alarm;
  logic  todin;
  logic  tod;
  logic  tick;
  logic  running;
  logic  latch_en;
  logic  sel_latch;
  logic  clk_we;
  logic  alarm_we;

  // Bus side: drives strobes, accesses and the pad
  modport master (
    output phi2_up, phi2_dn, rd, we, addr, w_alarm, todin, tod,
    input  tick, running, latch_en, sel_latch, clk_we, alarm_we
  );

  // Sequencer side
  modport slave (
    input  phi2_up, phi2_dn, rd, we, addr, w_alarm, todin, tod,
    output tick, running, latch_en, sel_latch, clk_we, alarm_we
  );

endinterface
`default_nettype wire

// File: rtl/cia_tod_div.sv
`default_nettype none
// ============================================================================
//  Module   : cia_tod_div
//  Purpose  : Modulo-5/6 pad-edge divider producing the 10 Hz count strobe.
//  Revision : 1.0  initial release
// ============================================================================
module cia_tod_div
  import cia_tod_ctrl_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic en,     // qualified pad rising edge
  input  logic run,    // clock running
  input  logic clr,    // hours write: clear and suppress
  input  logic div50,  // 1 = divide by 5, 0 = divide by 6
  output logic tick
);

  logic [2:0] cnt;
  logic [2:0] last;

  // '>=' rather than '==' so a count left at 5 by a 60->50 Hz switch wraps
  assign last = (div50 ? TOD_DIV50 : TOD_DIV60) - 3'd1;

  // Count pad edges while running; clear dominates and kills a due tick
  always_ff @(posedge clk) begin
    if (res) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr || !run) begin
        cnt <= '0;
      end else if (en) begin
        if (cnt >= last) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cia_tod_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cia_tod_ctrl
//  Purpose  : TOD sequencer: pad conditioning, 10 Hz divider, run and
//             read-latch state machines, TOD write decode.
//  Revision : 1.0  initial release
// ============================================================================
module cia_tod_ctrl
  import cia_tod_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 4
)(
  input  logic           clk,
  input  logic           res,
  cia_tod_ctrl_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  typedef logic [PW-1:0] pcnt_t;

  logic [SYNC_STAGES-1:0] sync;
  pcnt_t                  pcnt;
  logic                   tod_s;
  logic                   tod_lvl;
  logic                   smp;
  logic                   tod_edge;
  logic                   addr_hit;
  logic                   clk_sel;
  logic                   wr_start;
  logic                   wr_stop;
  logic                   rd_hold;
  logic                   rd_live;
  tod_run_t               run_st;
  tod_rd_t                rd_st;
  logic                   run_q;
  logic                   sel_q;
  logic                   lat_q;

  assign tod_lvl  = sync[SYNC_STAGES-1];
  assign smp      = bus.phi2_dn && ((PRESCALE == 1) || (pcnt == '0));
  assign tod_edge = smp && !tod_s && tod_lvl;

  // Write decode is combinational and not qualified by phi2
  assign addr_hit     = (bus.addr[3:2] == 2'b10);
  assign bus.clk_we   = bus.we && addr_hit && !bus.w_alarm;
  assign bus.alarm_we = bus.we && addr_hit &&  bus.w_alarm;

  // State machines only act on clock-register accesses at phi2_dn
  assign clk_sel  = bus.phi2_dn && !bus.w_alarm;
  assign wr_start = clk_sel && bus.we && (bus.addr == REG_TOD_10THS);
  assign wr_stop  = clk_sel && bus.we && (bus.addr == REG_TOD_HR);
  assign rd_live  = clk_sel && bus.rd && (bus.addr == REG_TOD_10THS);
  assign rd_hold  = clk_sel && bus.rd && (bus.addr == REG_TOD_HR);

  assign bus.running   = run_q;
  assign bus.sel_latch = sel_q;
  assign bus.latch_en  = lat_q;

  // Pad synchroniser into the clk domain
  always_ff @(posedge clk) begin
    if (res) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], bus.tod};
  end

  // PHI2 prescaler and once-per-PRESCALE pad sample
  always_ff @(posedge clk) begin
    if (res) begin
      pcnt  <= '0;
      tod_s <= 1'b0;
    end else begin
      if (bus.phi2_up) pcnt <= pcnt + pcnt_t'(1);
      if (smp)         tod_s <= tod_lvl;
    end
  end

  // Run FSM: 10ths write starts, hours write stops
  always_ff @(posedge clk) begin
    if (res) begin
      run_st <= TOD_STOPPED;
      run_q  <= 1'b0;
    end else begin
      case (run_st)
        TOD_STOPPED: if (wr_start) begin
          run_st <= TOD_RUNNING;
          run_q  <= 1'b1;
        end
        TOD_RUNNING: if (wr_stop) begin
          run_st <= TOD_STOPPED;
          run_q  <= 1'b0;
        end
        default: begin
          run_st <= TOD_STOPPED;
          run_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: hours read freezes the latch, 10ths read releases it
  always_ff @(posedge clk) begin
    if (res) begin
      rd_st <= TOD_LIVE;
      sel_q <= 1'b0;
      lat_q <= 1'b1;
    end else begin
      case (rd_st)
        TOD_LIVE: if (rd_hold) begin
          rd_st <= TOD_HELD;
          sel_q <= 1'b1;
          lat_q <= 1'b0;
        end
        TOD_HELD: if (rd_live) begin
          rd_st <= TOD_LIVE;
          sel_q <= 1'b0;
          lat_q <= 1'b1;
        end
        default: begin
          rd_st <= TOD_LIVE;
          sel_q <= 1'b0;
          lat_q <= 1'b1;
        end
      endcase
    end
  end

  cia_tod_div u_div (
    .clk   (clk),
    .res   (res),
    .en    (tod_edge),
    .run   (run_q),
    .clr   (wr_stop),
    .div50 (bus.todin),
    .tick  (bus.tick)
  );

endmodule
`default_nettype wire

// File: tb/tb_cia_tod_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cia_tod_ctrl
//  Purpose  : Self-checking bench for cia_tod_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cia_tod_ctrl;
  import cia_tod_ctrl_pkg::*;

  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  cia_tod_ctrl_if bus();

  cia_tod_ctrl #(.SYNC_STAGES(2), .PRESCALE(PRESCALE)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_ticks  = 0;
  int n_awe    = 0;
  int n_cwe    = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts PHI2 periods, samples the pad every PRESCALE periods, and counts
  // rising pad samples since the last tick; a tick fires when that count
  // reaches the current divide ratio.
  int m_ups, m_edges, m_div;
  bit m_last, m_run, m_held, m_tick, m_rise, m_stop, m_start;

  always @(posedge clk) begin
    if (res) begin
      m_ups = 0; m_edges = 0; m_last = 0; m_run = 0; m_held = 0; m_tick = 0;
    end else begin
      m_tick  = 0;
      m_stop  = bus.phi2_dn && bus.we && !bus.w_alarm && bus.addr == 4'd11;
      m_start = bus.phi2_dn && bus.we && !bus.w_alarm && bus.addr == 4'd8;
      if (bus.phi2_up) m_ups++;
      m_rise = 0;
      if (bus.phi2_dn && (m_ups % PRESCALE) == 0) begin
        m_rise = bus.tod && !m_last;
        m_last = bus.tod;
      end
      m_div = bus.todin ? 5 : 6;
      if (m_stop) m_edges = 0;
      else if (m_rise && m_run) begin
        m_edges++;
        if (m_edges >= m_div) begin m_edges = 0; m_tick = 1; end
      end
      if (m_stop) m_run = 0;
      else if (m_start) m_run = 1;
      if (bus.phi2_dn && bus.rd && !bus.w_alarm) begin
        if (bus.addr == 4'd11) m_held = 1;
        else if (bus.addr == 4'd8) m_held = 0;
      end
    end
  end

  // Compare every cycle, midway between active edges
  always @(negedge clk) begin
    if (started) begin
      chk("tick",      bus.tick,      m_tick);
      chk("running",   bus.running,   m_run);
      chk("sel_latch", bus.sel_latch, m_held);
      chk("latch_en",  bus.latch_en,  !m_held);
      chk("clk_we",    bus.clk_we,
          bus.we && !bus.w_alarm && bus.addr >= 4'd8 && bus.addr <= 4'd11);
      chk("alarm_we",  bus.alarm_we,
          bus.we &&  bus.w_alarm && bus.addr >= 4'd8 && bus.addr <= 4'd11);
      if (bus.tick)     n_ticks++;
      if (bus.alarm_we) n_awe++;
      if (bus.clk_we)   n_cwe++;
    end
  end

  // ---------------- stimulus ----------------
  // One PHI2 period of six clks; entered and left at posedge+1
  task automatic phi2_cycle();
    bus.phi2_up = 1; @(posedge clk); #1;
    bus.phi2_up = 0; @(posedge clk); #1;
    @(posedge clk); #1;
    bus.phi2_dn = 1; @(posedge clk); #1;
    bus.phi2_dn = 0; @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // PRESCALE PHI2 periods with the pad held; the last one carries the sample.
  // An optional access is held for the whole period numbered slot.
  task automatic quad(input bit pad, input int slot, input bit a_rd, input bit a_we,
                      input bit a_wa, input logic [3:0] a_addr);
    bus.tod = pad;
    for (int i = 0; i < PRESCALE; i++) begin
      if (i == slot) begin
        bus.rd = a_rd; bus.we = a_we; bus.w_alarm = a_wa; bus.addr = a_addr;
      end
      phi2_cycle();
      bus.rd = 0; bus.we = 0; bus.w_alarm = 0; bus.addr = 4'h0;
    end
  endtask

  task automatic pad_edges(input int n);
    for (int i = 0; i < n; i++) begin
      quad(1, -1, 0, 0, 0, 4'h0);
      quad(0, -1, 0, 0, 0, 4'h0);
    end
  endtask

  task automatic access(input bit a_rd, input bit a_we, input bit a_wa, input logic [3:0] a_addr);
    quad(0, 0, a_rd, a_we, a_wa, a_addr);
  endtask

  int base, base2;

  initial begin
    bus.phi2_up = 0; bus.phi2_dn = 0; bus.rd = 0; bus.we = 0; bus.addr = 4'h0;
    bus.w_alarm = 0; bus.todin = 0; bus.tod = 0;
    @(posedge clk); #1 started = 1;
    repeat (2) @(posedge clk);
    #1 res = 0;

    // Reset state
    chk("rst_running",  bus.running,   0);
    chk("rst_latch_en", bus.latch_en,  1);
    chk("rst_sel",      bus.sel_latch, 0);
    chk("rst_tick",     bus.tick,      0);
    chk("rst_cnt",      dut.u_div.cnt, 0);

    // 1: start at 60 Hz, tick every 6 edges
    access(0, 1, 0, 4'h8);
    chk("t1_running", bus.running, 1);
    base = n_ticks;
    for (int k = 1; k <= 12; k++) begin
      pad_edges(1);
      chk("t1_ticks", n_ticks - base, k / 6);
    end
    chk("t1_total", n_ticks - base, 2);

    // 2: 50 Hz, tick every 5 edges; then the 60->50 switch at count 5
    bus.todin = 1;
    base = n_ticks;
    for (int k = 1; k <= 10; k++) begin
      pad_edges(1);
      chk("t2_ticks50", n_ticks - base, k / 5);
    end
    bus.todin = 0;
    base = n_ticks;
    pad_edges(5);
    chk("t2_no_tick", n_ticks - base, 0);
    chk("t2_cnt5",    dut.u_div.cnt,  5);
    bus.todin = 1;
    pad_edges(1);
    chk("t2_switch_tick", n_ticks - base, 1);
    chk("t2_cnt0",        dut.u_div.cnt,  0);

    // 3: hours write on the sampling phi2_dn of the due edge
    bus.todin = 0;
    base = n_ticks;
    pad_edges(5);
    quad(1, PRESCALE - 1, 0, 1, 0, 4'hB);
    quad(0, -1, 0, 0, 0, 4'h0);
    chk("t3_suppressed", n_ticks - base, 0);
    chk("t3_stopped",    bus.running,    0);
    pad_edges(20);
    chk("t3_quiet", n_ticks - base, 0);

    // 4: read latch control
    access(1, 0, 0, 4'hB);
    chk("t4_hold_sel", bus.sel_latch, 1);
    chk("t4_hold_len", bus.latch_en,  0);
    access(1, 0, 0, 4'h9);
    chk("t4_rd9_sel", bus.sel_latch, 1);
    access(1, 0, 0, 4'h8);
    chk("t4_live_sel", bus.sel_latch, 0);
    chk("t4_live_len", bus.latch_en,  1);

    // 5: alarm writes decode but never touch the run state
    base = n_awe; base2 = n_cwe;
    access(0, 1, 1, 4'h8);
    chk("t5_still_stopped", bus.running, 0);
    access(0, 1, 1, 4'hB);
    chk("t5_awe_cycles", n_awe - base,  12);
    chk("t5_cwe_cycles", n_cwe - base2, 0);
    access(0, 1, 0, 4'h8);
    chk("t5_started", bus.running, 1);
    access(0, 1, 1, 4'hB);
    chk("t5_still_running", bus.running, 1);

    // 6: reset mid-count while held and running
    pad_edges(3);
    access(1, 0, 0, 4'hB);
    chk("t6_cnt3", dut.u_div.cnt,  3);
    chk("t6_held", bus.sel_latch,  1);
    res = 1;
    @(posedge clk); #1 res = 0;
    chk("t6_running", bus.running,   0);
    chk("t6_sel",     bus.sel_latch, 0);
    chk("t6_len",     bus.latch_en,  1);
    chk("t6_tick",    bus.tick,      0);
    chk("t6_cnt",     dut.u_div.cnt, 0);
    @(posedge clk); #1;
    chk("t6_release_tick", bus.tick, 0);
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
